// File: rtl/fb_fill_arbiter.sv
// Framebuffer write-port owner: arbitrates CPU pixel writes against a raster-order
// rectangle fill sequencer, with a starvation limit so the fill always progresses.
module fb_fill_arbiter #(
  parameter int COORD_W      = 6,
  parameter int DATA_W       = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_valid,
  input  logic [COORD_W-1:0] cpu_x,
  input  logic [COORD_W-1:0] cpu_y,
  input  logic [DATA_W-1:0]  cpu_data,
  output logic               cpu_ready,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_x1,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_y1,
  input  logic [DATA_W-1:0]  fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic [DATA_W-1:0]  fb_data,
  output logic               fb_we
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   starve_cnt;
  logic [COORD_W-1:0] xmin, xmax, ymax;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [DATA_W-1:0]  color;

  logic               in_fill;
  logic               starved;
  logic               cpu_grant;
  logic               fill_grant;
  logic               last_pixel;
  logic [COORD_W-1:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;

  // Handshake: a CPU write is accepted on any cycle where cpu_valid && cpu_ready;
  // the requester holds x/y/data stable until then. cpu_ready only drops on the
  // single cycle where a starved fill takes the port.
  assign in_fill    = (state == S_FILL);
  assign starved    = (starve_cnt == LIMIT);
  assign cpu_ready  = !in_fill || !starved;
  assign cpu_grant  = cpu_valid && cpu_ready;
  assign fill_grant = in_fill && (!cpu_valid || starved);
  assign last_pixel = (cur_x == xmax) && (cur_y == ymax);
  assign fill_busy  = in_fill;

  assign nxt_xmin = (fill_x0 < fill_x1) ? fill_x0 : fill_x1;
  assign nxt_xmax = (fill_x0 < fill_x1) ? fill_x1 : fill_x0;
  assign nxt_ymin = (fill_y0 < fill_y1) ? fill_y0 : fill_y1;
  assign nxt_ymax = (fill_y0 < fill_y1) ? fill_y1 : fill_y0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_x      <= '0;
      fb_y      <= '0;
      fb_data   <= '0;
      fb_we     <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fb_we     <= cpu_grant || fill_grant;
      fill_done <= fill_grant && last_pixel;
      if (cpu_grant) begin
        fb_x    <= cpu_x;
        fb_y    <= cpu_y;
        fb_data <= cpu_data;
      end else if (fill_grant) begin
        fb_x    <= cur_x;
        fb_y    <= cur_y;
        fb_data <= color;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      xmin       <= '0;
      xmax       <= '0;
      ymax       <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      color      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          starve_cnt <= '0;
          if (fill_start) begin
            xmin  <= nxt_xmin;
            xmax  <= nxt_xmax;
            ymax  <= nxt_ymax;
            cur_x <= nxt_xmin;
            cur_y <= nxt_ymin;
            color <= fill_color;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (cpu_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
          end else if (fill_grant) begin
            starve_cnt <= '0;
          end
          // Equality compares only, so a 0..max rectangle never wraps the cursor.
          if (fill_grant) begin
            if (last_pixel) begin
              state <= S_IDLE;
            end else if (cur_x == xmax) begin
              cur_x <= xmin;
              cur_y <= cur_y + 1'b1;
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
